// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter that shares one fixed-latency FPU datapath
// between two requesters and routes each result back to whichever requester
// issued the operation.
module fpu_arbiter #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [1:0]  req0_op,
   input  logic [1:0]  req1_op,
   input  logic        hold,
   output logic        fpu_start,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_op,
   input  logic        fpu_result_valid,
   input  logic [31:0] fpu_result,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp0_result,
   output logic [31:0] rsp1_result,
   output logic        idle,
   output logic        err
);

   // Round-robin pointer: requester that wins when both are valid.
   logic                 rr_ptr;
   // Requester id travelling with the operation in the issue stage.
   logic                 issue_id_p0;
   // In-flight tag pipeline; the last slot lines up with fpu_result_valid.
   logic [LATENCY-1:0]   tag_vld_p1;
   logic [LATENCY-1:0]   tag_id_p1;
   logic                 grant0;
   logic                 grant1;
   logic                 final_vld;
   logic                 final_id;
   logic                 hit0;
   logic                 hit1;

   // Combinational grant: a lone requester wins, ties go to the pointer, hold blocks all.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!hold) begin
         grant0 = req0_valid && (!req1_valid || !rr_ptr);
         grant1 = req1_valid && (!req0_valid ||  rr_ptr);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign final_vld = tag_vld_p1[LATENCY-1];
   assign final_id  = tag_id_p1[LATENCY-1];
   assign hit0      = final_vld && fpu_result_valid && !final_id;
   assign hit1      = final_vld && fpu_result_valid &&  final_id;

   assign idle = !fpu_start && (tag_vld_p1 == '0);

   // ---- stage p0: register the granted operation onto the FPU issue port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= 1'b0;
         fpu_start   <= 1'b0;
         issue_id_p0 <= 1'b0;
         fpu_a       <= '0;
         fpu_b       <= '0;
         fpu_op      <= '0;
      end else begin
         fpu_start <= grant0 || grant1;
         if (grant0 || grant1) begin
            // Pointer moves to the requester that lost (or was absent).
            rr_ptr      <= grant0;
            issue_id_p0 <= grant1;
         end
         if (grant1) begin
            fpu_a  <= req1_a;
            fpu_b  <= req1_b;
            fpu_op <= req1_op;
         end else if (grant0) begin
            fpu_a  <= req0_a;
            fpu_b  <= req0_b;
            fpu_op <= req0_op;
         end
      end
   end

   // ---- stage p1: shift the {valid, id} tag alongside the FPU pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_p1 <= '0;
         tag_id_p1  <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            tag_vld_p1[i] <= tag_vld_p1[i-1];
            tag_id_p1[i]  <= tag_id_p1[i-1];
         end
         tag_vld_p1[0] <= fpu_start;
         tag_id_p1[0]  <= issue_id_p0;
      end
   end

   // ---- stage p2: steer the returning result and flag tag/result disagreement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid  <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp1_result <= '0;
         err         <= 1'b0;
      end else begin
         rsp0_valid <= hit0;
         rsp1_valid <= hit1;
         if (hit0) rsp0_result <= fpu_result;
         if (hit1) rsp1_result <= fpu_result;
         // Result with no tag, or tag with no result: both are unrecoverable.
         if (final_vld != fpu_result_valid) err <= 1'b1;
      end
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL provide parameter LATENCY, default 3, meaning fixed cycles from fpu_start to matching fpu_result_valid (legal 1..8).
REQ-002 SHALL provide ports, in order: clk  input  1  sole clock, rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide req0_valid  input  1 and req1_valid  input  1, each meaning requester N presents an operation.
REQ-004 SHALL provide req0_ready  output  1 and req1_ready  output  1, each meaning requester N is granted this cycle.
REQ-005 SHALL provide req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-006 SHALL provide req0_op and req1_op  input  2  operator code, passed through unchanged.
REQ-007 SHALL provide hold  input  1  meaning block new grants.
REQ-008 SHALL provide fpu_start  output  1, fpu_a and fpu_b  output  32, and fpu_op  output  2, together forming the issue port to the shared FPU datapath.
REQ-009 SHALL provide fpu_result_valid  input  1 and fpu_result  input  32, forming the FPU return port.
REQ-010 SHALL provide rsp0_valid and rsp1_valid  output  1, and rsp0_result and rsp1_result  output  32, each pair meaning the result returned to requester N.
REQ-011 SHALL provide idle  output  1 (no operation in flight) and err  output  1 (sticky protocol error).

Function
REQ-012 SHALL compute grants combinationally: with hold=0, a single valid requester is granted; with both valid, the requester selected by the round-robin pointer is granted.
REQ-013 SHALL grant at most one requester per cycle, and SHALL drive reqN_ready=0 for both requesters while hold=1.
REQ-014 SHALL treat a cycle with reqN_valid and reqN_ready both high as a transfer.
REQ-015 SHALL set the round-robin pointer to the non-granted requester after each transfer, and SHALL leave the pointer unchanged when no transfer occurs.
REQ-016 SHALL, for a transfer in cycle N, drive fpu_start=1 in cycle N+1 with fpu_a, fpu_b and fpu_op registered from the granted requester.
REQ-017 SHALL drive fpu_start=0 in cycles with no preceding transfer, and SHALL hold fpu_a, fpu_b and fpu_op at their last values in those cycles.
REQ-018 SHALL track in-flight operations with a LATENCY-deep shift register of {valid, id} entries, inserting an entry on every fpu_start and advancing it every cycle.
REQ-019 SHALL, when the final tag slot is valid and fpu_result_valid=1, drive rspID_valid=1 and rspID_result=fpu_result in the next cycle, and SHALL drive the other rsp_valid to 0.
REQ-020 SHALL support back-to-back issue every cycle, giving a sustained throughput of one operation per cycle.
REQ-021 SHALL therefore have a request-transfer-to-rsp latency of exactly LATENCY+2 cycles.
REQ-022 SHALL set err if fpu_result_valid=1 while the final tag slot is empty, and SHALL drop that result with no rsp_valid pulse.
REQ-023 SHALL set err if the final tag slot is valid while fpu_result_valid=0; the corresponding response SHALL be lost.
REQ-024 SHALL keep err set until reset.
REQ-025 SHALL drive idle=1 exactly when fpu_start=0 and all tag slots are empty.
REQ-026 SHALL let operations already in flight complete normally when hold is asserted mid-stream.

Reset
REQ-027 SHALL, on rst_n=0, immediately and asynchronously clear: fpu_start, rsp0_valid, rsp1_valid, err, all tag slots, and the round-robin pointer (pointer=requester 0); and SHALL set idle=1.
REQ-028 SHALL, on rst_n=0, clear fpu_a, fpu_b, fpu_op, rsp0_result and rsp1_result to 0.
REQ-029 SHALL discard operations in flight at reset, producing no responses and no err after release.
REQ-030 SHALL allow grants in the first clock edge after rst_n deasserts.

Verification
REQ-031 SHALL be verified with req0 alone (a=0x3FA00000, b=0x3FC00000, op=00) and a model FPU returning 0x40300000 after LATENCY=3 -> req0_ready=1 same cycle, fpu_start at +1, rsp0_valid=1 with 0x40300000 at +5, rsp1_valid=0.
REQ-032 SHALL be verified with both requesters valid for 4 cycles after reset -> grants 0,1,0,1, fpu_start high 4 consecutive cycles, and responses returned in the same order.
REQ-033 SHALL be verified with hold=1 while both requesters are valid -> both ready=0, fpu_start=0, idle=1 after in-flight responses drain.
REQ-034 SHALL be verified with fpu_result_valid pulsed while idle -> err=1 and stays 1, no rsp_valid pulse.
REQ-035 SHALL be verified with rst_n asserted for one cycle with 3 operations in flight -> outputs cleared asynchronously, no responses afterwards, err=0.
